dmi_req_arbiter: RTL
====================

Name: dmi_req_arbiter

Overview:
- TCK-domain arbiter that shares one DMI request/response channel (the dmi_cdc JTAG side) between two debug transport requesters, e.g. the JTAG DTM FSM and a scripted debug-sequence engine.
- Grants one transaction at a time in round-robin order and routes each response back to the requester that issued it.
- A response timeout stops a requester from hanging forever. Late responses that arrive after a timeout are dropped.

Parameters:
- TimeoutCycles, 1024, number of TCK cycles in WAIT_RESP before an error response is synthesised; legal range 2..65535.
- WaitWriteResp, 0, 1 = non-READ ops also wait for a downstream response; 0 = they complete on downstream accept.

Ports:
- tck_i  in  1  TCK clock
- trst_ni  in  1  reset, asynchronous, active-low
- req0_i  in  41  requester 0 request {addr[40:34], data[33:2], op[1:0]}
- req0_valid_i  in  1  requester 0 request valid
- req0_ready_o  out  1  requester 0 accept pulse
- resp0_o  out  34  requester 0 response {data[33:2], resp[1:0]}
- resp0_valid_o  out  1  requester 0 response valid, single-cycle pulse
- req1_i, req1_valid_i, req1_ready_o, resp1_o, resp1_valid_o  same as requester 0, for requester 1
- dmi_req_o  out  41  downstream request
- dmi_req_valid_o  out  1  downstream request valid
- dmi_req_ready_i  in  1  downstream accept
- dmi_resp_i  in  34  downstream response
- dmi_resp_valid_i  in  1  downstream response valid
- dmi_resp_ready_o  out  1  constant 1
- busy_o  out  1  state != IDLE
- owner_o  out  1  index of the current or last granted requester
- timeout_o  out  1  one-cycle pulse when a timeout fires

Behaviour:
- Reset values:
  - state = IDLE; rr_q = 0; owner = 0; timer = 0; stale_cnt = 0; hold register = 0.
  - All valid, ready and pulse outputs = 0; resp*_o = 0; dmi_req_o = 0.
- Op encoding: READ = 2'h1, WRITE = 2'h2. Any other op is handled as write-type.
- IDLE:
  - If any req*_valid_i is high, grant one requester. With both valid, grant requester rr_q; otherwise grant the single valid one.
  - In the same cycle: pulse that requester's req*_ready_o, latch its request into the hold register, set owner, then go to ISSUE.
  - Accept-to-downstream-valid latency is 1 cycle.
- ISSUE:
  - dmi_req_valid_o = 1 and dmi_req_o = hold register, held stable until dmi_req_ready_i.
  - On accept: if op == READ or WaitWriteResp = 1, go to WAIT_RESP with timer = 0. Otherwise go to IDLE.
  - No timeout applies in ISSUE.
- WAIT_RESP:
  - Increment timer each cycle.
  - On a dmi_resp_valid_i that is not consumed as stale: drive resp<owner>_o = dmi_resp_i, pulse resp<owner>_valid_o for one cycle, go to IDLE.
  - If timer == TimeoutCycles-1 and no non-stale response arrives that cycle: drive resp<owner>_o = {32'h0, 2'h2}, pulse resp<owner>_valid_o and timeout_o, increment stale_cnt (saturating at 15), go to IDLE.
- Stale responses, in any state: a dmi_resp_valid_i while stale_cnt != 0 is consumed and not forwarded, and stale_cnt decrements. If this coincides with a timeout in the same cycle, stale_cnt is unchanged (net 0).
- Round robin: on every transition out of ISSUE or WAIT_RESP that returns to IDLE, rr_q <= ~owner. A requester is never granted twice in a row while the other is valid.
- A dmi_resp_valid_i in IDLE or ISSUE with stale_cnt == 0 is dropped silently.
- Back-to-back operation: IDLE can grant in the cycle after returning from the previous transaction. Minimum transaction spacing is 2 cycles for writes and 3 cycles for reads.
- Reset asserted mid-transaction aborts the transaction immediately: no response is emitted and all state returns to reset values.

Decomposition:
- Shared package (dm_pkg extension):
  - DTM op constants (NOP, READ, WRITE).
  - Response codes (SUCCESS 2'h0, FAILED 2'h2, BUSY 2'h3).
  - Request/response widths 41/34 and field offsets.
- One sub-module, rr_arb2: 2-way round-robin grant logic holding rr_q. All other logic lives in the top.

Test Plan:
- Single read: req0 = {7'h11, 32'h0, READ}; downstream ready at cycle 2; response {32'hCAFEF00D, 2'h0} after 5 cycles -> resp0_o = 34'h{CAFEF00D, 0}, resp0_valid_o pulses once, resp1_valid_o stays 0, busy_o returns to 0.
- Contention: both valid with writes from reset -> requester 0 granted first, then requester 1. Both keep requesting -> grants alternate 0,1,0,1 and dmi_req_o fields match the granted source each time.
- Timeout: TimeoutCycles = 8, read with no downstream response -> after 8 WAIT_RESP cycles, resp0_o = {32'h0, 2'h2} and timeout_o pulses. A response injected 3 cycles later is not forwarded and stale_cnt returns to 0.
- Stale with new transaction: after the timeout, req1 reads immediately. The first downstream response is dropped; the second reaches resp1_o with value 34'h{12345678, 0}.
- WaitWriteResp = 1: write accepted -> busy_o stays 1 until the downstream response, which is then forwarded. With WaitWriteResp = 0 the same write returns to IDLE on accept and no resp*_valid_o pulses.
- Reset mid-read: assert trst_ni low during WAIT_RESP -> all outputs return to 0 asynchronously. After release, the next grant goes to requester 0.

Source files
------------

// File: rtl/dmi_req_arbiter_pkg.sv
// Shared DMI definitions for the TCK-domain request arbiter: DTM op and
// response encodings, request/response layouts and the arbiter state type.
package dmi_req_arbiter_pkg;

    // Request/response widths and field offsets.
    localparam int unsigned DMI_ADDR_W    = 7;
    localparam int unsigned DMI_DATA_W    = 32;
    localparam int unsigned DMI_OP_W      = 2;
    localparam int unsigned DMI_REQ_W     = DMI_ADDR_W + DMI_DATA_W + DMI_OP_W;  // 41
    localparam int unsigned DMI_RESP_W    = DMI_DATA_W + 2;                      // 34
    localparam int unsigned DMI_OP_LSB    = 0;
    localparam int unsigned DMI_DATA_LSB  = 2;
    localparam int unsigned DMI_ADDR_LSB  = 34;
    localparam int unsigned DMI_RESP_LSB  = 0;
    localparam int unsigned DMI_RDATA_LSB = 2;

    // DTM operation codes; anything that is not READ is treated as write-type.
    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    // DTM response codes.
    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'h0,
        DTM_FAILED  = 2'h2,
        DTM_BUSY    = 2'h3
    } dtm_resp_e;

    typedef struct packed {
        logic [DMI_ADDR_W-1:0] addr;
        logic [DMI_DATA_W-1:0] data;
        logic [DMI_OP_W-1:0]   op;
    } dmi_req_t;

    typedef struct packed {
        logic [DMI_DATA_W-1:0] data;
        logic [1:0]            resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_e;

    // True when the op expects read data back from the debug module.
    function automatic logic op_is_read(input logic [DMI_OP_W-1:0] op);
        return op == DTM_READ;
    endfunction

    // Response synthesised when the downstream side never answers.
    function automatic dmi_resp_t timeout_resp();
        dmi_resp_t r;
        r.data = '0;
        r.resp = DTM_FAILED;
        return r;
    endfunction

endpackage

// File: rtl/dmi_req_arbiter_rr_arb2.sv
// Two-way round-robin grant logic. The pointer names the requester that wins
// when both are valid; it flips to the other side whenever a transaction ends.
module rr_arb2 (
    input  logic       tck_i,
    input  logic       trst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       last_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic rr_q;

    // Priority pointer: after a transaction ends, the non-owner goes first.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            rr_q <= 1'b0;
        end else if (update_i) begin
            rr_q <= ~last_i;
        end
    end

    // Grant the pointer on contention, otherwise the single valid requester.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = rr_q;
        if (req_i == 2'b01) begin
            gnt_idx_o = 1'b0;
        end else if (req_i == 2'b10) begin
            gnt_idx_o = 1'b1;
        end
    end

endmodule

// File: rtl/dmi_req_arbiter.sv
// Shares one DMI request/response channel between two debug requesters.
// One transaction is in flight at a time; the response is routed back to the
// requester that issued it. A response timeout unblocks the owner, and the
// late responses it leaves behind are counted and silently discarded.
module dmi_req_arbiter
    import dmi_req_arbiter_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,  // legal range 2..65535
    parameter bit          WaitWriteResp = 1'b0
) (
    input  logic                  tck_i,
    input  logic                  trst_ni,
    input  logic [DMI_REQ_W-1:0]  req0_i,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    output logic [DMI_RESP_W-1:0] resp0_o,
    output logic                  resp0_valid_o,
    input  logic [DMI_REQ_W-1:0]  req1_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    output logic [DMI_RESP_W-1:0] resp1_o,
    output logic                  resp1_valid_o,
    output logic [DMI_REQ_W-1:0]  dmi_req_o,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    input  logic [DMI_RESP_W-1:0] dmi_resp_i,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    output logic                  busy_o,
    output logic                  owner_o,
    output logic                  timeout_o
);

    // Last timer value in WAIT_RESP before the error response is synthesised.
    localparam logic [15:0] TimerLast = 16'(TimeoutCycles - 1);
    localparam logic [3:0]  StaleMax  = 4'hF;

    arb_state_e state_q, state_d;
    dmi_req_t   hold_q;
    logic       owner_q;
    logic [15:0] timer_q;
    logic [3:0]  stale_q;

    logic       gnt_valid;
    logic       gnt_idx;
    logic       grant_en;
    logic       rr_update;
    logic       stale_hit;
    logic       timeout_fire;
    logic       resp_pulse;
    dmi_resp_t  resp_val;

    rr_arb2 u_rr_arb2 (
        .tck_i       (tck_i),
        .trst_ni     (trst_ni),
        .req_i       ({req1_valid_i, req0_valid_i}),
        .update_i    (rr_update),
        .last_i      (owner_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // A response that arrives while older timed-out responses are still owed
    // belongs to one of those, never to the current transaction.
    assign stale_hit = dmi_resp_valid_i && (stale_q != '0);

    // Next-state and per-cycle handshake decode.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_en     = 1'b0;
        rr_update    = 1'b0;
        timeout_fire = 1'b0;
        resp_pulse   = 1'b0;
        resp_val     = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant_en = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (dmi_req_ready_i) begin
                    if (op_is_read(hold_q.op) || WaitWriteResp) begin
                        state_d = ST_WAIT_RESP;
                    end else begin
                        state_d   = ST_IDLE;
                        rr_update = 1'b1;
                    end
                end
            end

            ST_WAIT_RESP: begin
                if (dmi_resp_valid_i && !stale_hit) begin
                    resp_pulse = 1'b1;
                    resp_val   = dmi_resp_t'(dmi_resp_i);
                    state_d    = ST_IDLE;
                    rr_update  = 1'b1;
                end else if (timer_q == TimerLast) begin
                    timeout_fire = 1'b1;
                    resp_pulse   = 1'b1;
                    resp_val     = timeout_resp();
                    state_d      = ST_IDLE;
                    rr_update    = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted request and remember who owns the transaction.
    // NOTE: the hold register is reset even though it is datapath, so the
    // downstream request bus reads as zero until the first grant.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            hold_q  <= '0;
            owner_q <= 1'b0;
        end else if (grant_en) begin
            hold_q  <= gnt_idx ? dmi_req_t'(req1_i) : dmi_req_t'(req0_i);
            owner_q <= gnt_idx;
        end
    end

    // Response timer: counts WAIT_RESP cycles, zero in every other state.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            timer_q <= '0;
        end else if (state_q == ST_WAIT_RESP) begin
            timer_q <= timer_q + 16'd1;
        end else begin
            timer_q <= '0;
        end
    end

    // Count responses still owed by timed-out transactions; a timeout and a
    // consumed stale response in the same cycle cancel out.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            stale_q <= '0;
        end else if (timeout_fire && !stale_hit) begin
            if (stale_q != StaleMax) begin
                stale_q <= stale_q + 4'd1;
            end
        end else if (stale_hit && !timeout_fire) begin
            stale_q <= stale_q - 4'd1;
        end
    end

    assign req0_ready_o     = grant_en && !gnt_idx;
    assign req1_ready_o     = grant_en && gnt_idx;

    assign resp0_valid_o    = resp_pulse && !owner_q;
    assign resp1_valid_o    = resp_pulse && owner_q;
    assign resp0_o          = resp0_valid_o ? resp_val : '0;
    assign resp1_o          = resp1_valid_o ? resp_val : '0;

    assign dmi_req_o        = hold_q;
    assign dmi_req_valid_o  = (state_q == ST_ISSUE);
    assign dmi_resp_ready_o = 1'b1;

    assign busy_o           = (state_q != ST_IDLE);
    assign owner_o          = owner_q;
    assign timeout_o        = timeout_fire;

endmodule
